// File: rtl/pwm_dc_feeder.sv
// Duty-cycle sample FIFO fed over the register bus. It releases one sample every INTERVAL cycles
// to the PWM. The strobe is registered, appearing 1 cycle after the tick, and the bus never stalls.
`timescale 1ns/1ps
module pwm_dc_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        error_o,
  output logic [15:0] o_DC,
  output logic        o_valid_DC,
  output logic        o_irq
);

  localparam logic [7:0]  A_CTRL     = 8'h00;
  localparam logic [7:0]  A_INTERVAL = 8'h04;
  localparam logic [7:0]  A_DATA     = 8'h08;
  localparam logic [7:0]  A_STATUS   = 8'h0C;
  localparam logic [7:0]  A_WMARK    = 8'h10;
  localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);

  logic          en_q, en_d, rep_q, rep_d, irqen_q, irqen_d;
  logic [15:0]   interval_q, interval_d;
  logic [AW:0]   wmark_q, wmark_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          unf_q, unf_d, ovf_q, ovf_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   dc_q, dc_d;
  logic          vld_q, vld_d;
  logic          irq_q, irq_d;
  logic [15:0]   mem [DEPTH];

  logic wr, sel_ctrl, sel_int, sel_data, sel_stat, sel_wm, mapped;
  logic empty, full, tick, pop, push, push_ok, flush;
  logic [15:0] reload;
  logic unused_ok;

  assign wr       = we_i & ~re_i;
  assign sel_ctrl = (addr_i == A_CTRL);
  assign sel_int  = (addr_i == A_INTERVAL);
  assign sel_data = (addr_i == A_DATA);
  assign sel_stat = (addr_i == A_STATUS);
  assign sel_wm   = (addr_i == A_WMARK);
  assign mapped   = sel_ctrl | sel_int | sel_data | sel_stat | sel_wm;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign reload  = (interval_q == 16'd0) ? 16'd0 : interval_q - 16'd1;
  assign tick    = en_q & (cnt_q == 16'd0);
  // A push on empty never bypasses a coincident tick; the tick sees the pre-push level.
  assign pop     = tick & ~empty;
  assign push    = wr & sel_data;
  assign push_ok = push & (~full | pop);
  assign flush   = wr & sel_ctrl & wdata_i[2];

  assign error_o   = ((re_i | we_i) & ~mapped) | (push & full & ~pop);
  assign unused_ok = ^{be_i, wdata_i[31:16]};

  always_comb begin
    rdata_o = '0;
    unique case (1'b1)
      sel_ctrl: rdata_o[3:0] = {irqen_q, 1'b0, rep_q, en_q};
      sel_int:  rdata_o[15:0] = interval_q;
      sel_data: rdata_o[15:0] = empty ? 16'd0 : mem[rptr_q];
      sel_stat: begin
        rdata_o[AW:0] = level_q;
        rdata_o[8]    = empty;
        rdata_o[9]    = full;
        rdata_o[10]   = unf_q;
        rdata_o[11]   = ovf_q;
      end
      sel_wm:   rdata_o[AW:0] = wmark_q;
      default:  rdata_o = '0;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    rep_d      = rep_q;
    irqen_d    = irqen_q;
    interval_d = interval_q;
    wmark_d    = wmark_q;
    if (wr && sel_ctrl) begin
      en_d    = wdata_i[0];
      rep_d   = wdata_i[1];
      irqen_d = wdata_i[3];
    end
    if (wr && sel_int) interval_d = wdata_i[15:0];
    if (wr && sel_wm)  wmark_d = wdata_i[AW:0];

    cnt_d = (!en_q || tick) ? reload : cnt_q - 16'd1;

    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end

    // Sticky set wins over a same-cycle write-1-to-clear.
    unf_d = (unf_q & ~(wr & sel_stat & wdata_i[10])) | (tick & empty);
    ovf_d = (ovf_q & ~(wr & sel_stat & wdata_i[11])) | (push & full & ~pop);

    dc_d  = pop ? mem[rptr_q] : dc_q;
    vld_d = tick & (~empty | rep_q);
    irq_d = irqen_q & ((level_q <= wmark_q) | unf_q | ovf_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      rep_q      <= 1'b0;
      irqen_q    <= 1'b0;
      interval_q <= '0;
      wmark_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      unf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      dc_q       <= '0;
      vld_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      rep_q      <= rep_d;
      irqen_q    <= irqen_d;
      interval_q <= interval_d;
      wmark_q    <= wmark_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      unf_q      <= unf_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      dc_q       <= dc_d;
      vld_q      <= vld_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_q] <= wdata_i[15:0];
  end

  assign o_DC       = dc_q;
  assign o_valid_DC = vld_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_pwm_dc_feeder.sv
// Directed bench for pwm_dc_feeder: streaming, repeat, overflow, full push+pop, watermark irq, async reset.
`timescale 1ns/1ps
module tb_pwm_dc_feeder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        re_i = 1'b0;
  logic        we_i = 1'b0;
  logic [7:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = 4'hF;
  logic [31:0] rdata_o;
  logic        error_o;
  logic [15:0] o_DC;
  logic        o_valid_DC;
  logic        o_irq;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] CTRL = 8'h00, INTV = 8'h04, DATA = 8'h08, STAT = 8'h0C, WMRK = 8'h10;

  pwm_dc_feeder #(.DEPTH(8), .AW(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .re_i(re_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_o), .error_o(error_o),
    .o_DC(o_DC), .o_valid_DC(o_valid_DC), .o_irq(o_irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_err(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge clk_i);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    #1 err = error_o;
    @(posedge clk_i);
    #1 we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e;
    wr_err(a, d, e);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr_i = a; re_i = 1'b1;
    #1 d = rdata_o;
    re_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
  endtask

  // gap-1 quiet cycles, then a strobe carrying dc.
  task automatic expect_pulse(input string tag, input int gap, input logic [15:0] dc);
    for (int i = 1; i < gap; i++) begin
      @(posedge clk_i); #1;
      check({tag, "_quiet"}, {31'd0, o_valid_DC}, 32'd0);
    end
    @(posedge clk_i); #1;
    check({tag, "_vld"}, {31'd0, o_valid_DC}, 32'd1);
    check({tag, "_dc"}, {16'd0, o_DC}, {16'd0, dc});
  endtask

  initial begin
    logic [31:0] r;
    logic        e;

    // Reset state
    #2;
    check("rst_vld", {31'd0, o_valid_DC}, 32'd0);
    check("rst_dc", {16'd0, o_DC}, 32'd0);
    check("rst_irq", {31'd0, o_irq}, 32'd0);
    do_reset();
    rd(CTRL, r); check("rst_ctrl", r, 32'h0);
    rd(INTV, r); check("rst_intv", r, 32'h0);
    rd(STAT, r); check("rst_stat", r, 32'h100);
    rd(WMRK, r); check("rst_wmark", r, 32'h0);
    rd(8'h14, r); check("unmapped_rd", r, 32'h0);
    addr_i = 8'h14; re_i = 1'b1; #1 check("unmapped_rd_err", {31'd0, error_o}, 32'd1); re_i = 1'b0;

    // Basic stream
    wr(INTV, 32'd4);
    rd(INTV, r); check("intv_rb", r, 32'd4);
    wr(DATA, 32'h10); wr(DATA, 32'h20); wr(DATA, 32'h30);
    rd(DATA, r); check("data_head", r, 32'h10);
    rd(STAT, r); check("stat_lvl3", r, 32'h3);
    wr(CTRL, 32'h1);
    expect_pulse("bs1", 4, 16'h0010);
    expect_pulse("bs2", 4, 16'h0020);
    expect_pulse("bs3", 4, 16'h0030);
    repeat (4) @(posedge clk_i);
    #1 check("bs_no_repeat", {31'd0, o_valid_DC}, 32'd0);
    rd(STAT, r); check("bs_stat", r, 32'h500);

    // REPEAT
    do_reset();
    wr(INTV, 32'd4);
    wr(DATA, 32'h10); wr(DATA, 32'h20); wr(DATA, 32'h30);
    wr(CTRL, 32'h3);
    expect_pulse("rp1", 4, 16'h0010);
    expect_pulse("rp2", 4, 16'h0020);
    expect_pulse("rp3", 4, 16'h0030);
    expect_pulse("rp4", 4, 16'h0030);
    rd(STAT, r); check("rp_stat_unf", r, 32'h500);
    wr(STAT, 32'h400);
    rd(STAT, r); check("rp_stat_clr", r, 32'h100);
    repeat (3) @(posedge clk_i);
    #1;
    check("rp5_vld", {31'd0, o_valid_DC}, 32'd1);
    check("rp5_dc", {16'd0, o_DC}, 32'h30);
    rd(STAT, r); check("rp_stat_reset", r, 32'h500);

    // Overflow and flush
    do_reset();
    for (int k = 1; k <= 7; k++) wr(DATA, 32'h100 + k);
    wr_err(DATA, 32'h108, e); check("ov_8th_err", {31'd0, e}, 32'd0);
    rd(STAT, r); check("ov_full", r, 32'h208);
    wr_err(DATA, 32'h109, e); check("ov_9th_err", {31'd0, e}, 32'd1);
    rd(STAT, r); check("ov_sticky", r, 32'hA08);
    rd(DATA, r); check("ov_head", r, 32'h101);
    wr(CTRL, 32'h4);
    rd(STAT, r); check("flush_stat", r, 32'h900);
    rd(CTRL, r); check("flush_rd0", r, 32'h0);
    wr_err(8'h14, 32'h1, e); check("unmapped_wr_err", {31'd0, e}, 32'd1);

    // Full push+pop on a tick
    do_reset();
    wr(INTV, 32'd1);
    for (int k = 1; k <= 8; k++) wr(DATA, k);
    wr(CTRL, 32'h1);
    wr_err(DATA, 32'hBEEF, e); check("fpp_err", {31'd0, e}, 32'd0);
    check("fpp_p1_vld", {31'd0, o_valid_DC}, 32'd1);
    check("fpp_p1_dc", {16'd0, o_DC}, 32'd1);
    rd(STAT, r); check("fpp_lvl8", r, 32'h208);
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk_i); #1;
      check("fpp_dc", {15'd0, o_valid_DC, o_DC}, 32'h10000 + k);
    end
    @(posedge clk_i); #1;
    check("fpp_beef", {15'd0, o_valid_DC, o_DC}, 32'h1BEEF);
    @(posedge clk_i); #1;
    check("fpp_drained", {31'd0, o_valid_DC}, 32'd0);

    // Watermark IRQ
    do_reset();
    wr(WMRK, 32'd2);
    wr(INTV, 32'd2);
    wr(DATA, 32'hA); wr(DATA, 32'hB); wr(DATA, 32'hC); wr(DATA, 32'hD);
    check("wm_irq_off", {31'd0, o_irq}, 32'd0);
    wr(CTRL, 32'h9);
    @(posedge clk_i); #1 check("wm_t1_irq", {31'd0, o_irq}, 32'd0);
    @(posedge clk_i); #1 check("wm_t2_dc", {15'd0, o_valid_DC, o_DC}, 32'h1000A);
    @(posedge clk_i); #1 check("wm_t3_irq", {31'd0, o_irq}, 32'd0);
    @(posedge clk_i); #1 check("wm_t4_dc", {15'd0, o_valid_DC, o_DC}, 32'h1000B);
    check("wm_t4_irq", {31'd0, o_irq}, 32'd0);
    @(posedge clk_i); #1 check("wm_t5_irq", {31'd0, o_irq}, 32'd1);
    repeat (6) @(posedge clk_i);
    #1 check("wm_t11_irq", {31'd0, o_irq}, 32'd1);
    rd(STAT, r); check("wm_stat", r, 32'h500);

    // Async reset mid-pulse
    do_reset();
    wr(INTV, 32'd1);
    wr(DATA, 32'h55);
    wr(CTRL, 32'h9);
    @(posedge clk_i); #1 check("ar_pulse", {15'd0, o_valid_DC, o_DC}, 32'h10055);
    @(posedge clk_i); #1 check("ar_irq_hi", {31'd0, o_irq}, 32'd1);
    @(posedge clk_i); #1 check("ar_vld_rep0", {31'd0, o_valid_DC}, 32'd0);
    wr(CTRL, 32'hB);
    @(posedge clk_i); #1 check("ar_rep_vld", {15'd0, o_valid_DC, o_DC}, 32'h10055);
    #2 rst_ni = 1'b0;
    #1;
    check("ar_vld", {31'd0, o_valid_DC}, 32'd0);
    check("ar_dc", {16'd0, o_DC}, 32'd0);
    check("ar_irq", {31'd0, o_irq}, 32'd0);
    rd(CTRL, r); check("ar_ctrl", r, 32'h0);
    rd(INTV, r); check("ar_intv", r, 32'h0);
    rd(DATA, r); check("ar_data", r, 32'h0);
    rd(STAT, r); check("ar_stat", r, 32'h100);
    rd(WMRK, r); check("ar_wmark", r, 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
